// File: rtl/instr_prefetch_buffer_pkg.sv
// prefetch_pkg: shared types and helpers for the instruction prefetch buffer.
//   type_fetch_req_s : word fetch request towards the icache/MMU {req, addr}
//   type_fetch_rsp_s : icache/MMU response {ack, data}
//   type_pref_out_s  : instruction presented to the IF stage {valid, instr, pc, is_comp}
//   is_rvc()         : true when the low two bits mark a 16-bit (compressed) encoding
//   INSTR_NOP        : canonical 32-bit NOP (addi x0, x0, 0)
package prefetch_pkg;

    localparam int          PREF_XLEN = 32;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic                 req;
        logic [PREF_XLEN-1:0] addr;
    } type_fetch_req_s;

    typedef struct packed {
        logic        ack;
        logic [31:0] data;
    } type_fetch_rsp_s;

    typedef struct packed {
        logic                 valid;
        logic [31:0]          instr;
        logic [PREF_XLEN-1:0] pc;
        logic                 is_comp;
    } type_pref_out_s;

    function automatic logic is_rvc(input logic [1:0] low_bits);
        return low_bits != 2'b11;
    endfunction

endpackage

// File: rtl/instr_prefetch_buffer_if.sv
// instr_prefetch_buffer_if: fetch port and IF-stage port of the prefetch buffer.
//   fetch_req_o/fetch_addr_o  : word fetch request (buffer -> icache/MMU)
//   fetch_ack_i/fetch_data_i  : one-cycle response strobe with data (icache/MMU -> buffer)
//   instr_valid_o/instr_ready_i, instr_o, pc_o, is_comp_o : instruction handshake to IF
// Handshake semantics: an instruction transfers on every rising clk edge where
// instr_valid_o && instr_ready_i; the buffer holds instr_o/pc_o/is_comp_o stable
// while valid and not ready. A fetch request is accepted in the cycle fetch_req_o
// is high (no ready back-pressure); exactly one fetch_ack_i answers each request.
// Modports: master = prefetch buffer side, slave = icache + IF stage side.
interface instr_prefetch_buffer_if #(
    parameter int XLEN = 32
);
    logic            fetch_req_o;
    logic [XLEN-1:0] fetch_addr_o;
    logic            fetch_ack_i;
    logic [31:0]     fetch_data_i;
    logic            instr_valid_o;
    logic            instr_ready_i;
    logic [31:0]     instr_o;
    logic [XLEN-1:0] pc_o;
    logic            is_comp_o;

    modport master (
        output fetch_req_o, fetch_addr_o,
        input  fetch_ack_i, fetch_data_i,
        output instr_valid_o, instr_o, pc_o, is_comp_o,
        input  instr_ready_i
    );

    modport slave (
        input  fetch_req_o, fetch_addr_o,
        output fetch_ack_i, fetch_data_i,
        input  instr_valid_o, instr_o, pc_o, is_comp_o,
        output instr_ready_i
    );
endinterface

// File: rtl/instr_prefetch_buffer_fifo.sv
// pref_word_fifo: small word FIFO with two read ports (head and head+1).
//   clk, rst       : clock, synchronous active-high reset
//   clear          : empties the FIFO (pointers and count), dominates push/pop
//   push/push_data : write one word at the tail
//   pop            : drop the head word
//   count          : words held, log2(DEPTH)+1 bits
//   head/head_next : word at the head and the word after it (pointer wraps)
// Push and pop in the same cycle are allowed; the caller never pushes when full.
module pref_word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [$clog2(DEPTH):0] count,
    output logic [WIDTH-1:0]       head,
    output logic [WIDTH-1:0]       head_next
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rptr;
    logic [AW-1:0]    wptr;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage has no reset: contents are only observed through count-qualified reads.
    always_ff @(posedge clk) begin
        if (push && !clear && !rst) begin
            mem[wptr] <= push_data;
        end
    end

    assign head      = mem[rptr];
    assign head_next = mem[rptr + AW'(1)];

endmodule

// File: rtl/instr_prefetch_buffer.sv
// instr_prefetch_buffer: prefetches aligned 32-bit words into a DEPTH-word FIFO and
// hands 16-bit (RVC) and 32-bit instructions at any halfword alignment to IF.
//   clk, rst     : clock, synchronous active-high reset
//   flush_i      : redirect, dominates every other input
//   flush_pc_i   : redirect target (bit 0 ignored)
//   bus (master) : fetch request/response and instruction valid/ready port
//   stall_cnt_o, flush_cnt_o : saturating statistics counters, present only
//                  when the PREFETCH_STATS_EN macro is defined
module instr_prefetch_buffer
    import prefetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic [XLEN-1:0]   flush_pc_i,
    instr_prefetch_buffer_if.master bus
`ifdef PREFETCH_STATS_EN
    ,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       flush_cnt_o
`endif
);
    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW:0]     CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);

    logic [AW:0]     count;
    logic [31:0]     h0;
    logic [31:0]     h1;
    logic            pending_q;   // a fetch request is in flight
    logic            drop_q;      // the in-flight request predates a flush
    logic            offset_q;    // head halfword within h0
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] addr_q;

    type_fetch_req_s req_s;
    type_fetch_rsp_s rsp_s;
    type_pref_out_s  out_s;
    logic            comp;
    logic [31:0]     raw_instr;
    logic            fire;
    logic            push;
    logic            pop;

    logic            unused_bits;
    assign unused_bits = ^{flush_pc_i[0], h1[31:16]};

    always_comb begin
        rsp_s.ack  = bus.fetch_ack_i;
        rsp_s.data = bus.fetch_data_i;
        // Gated by rst so every output reads 0 while reset is held.
        req_s.req  = !rst && !pending_q && (count < CNT_FULL) && !flush_i;
        req_s.addr = addr_q;
    end

    // Instruction alignment from the two head words.
    always_comb begin
        comp      = offset_q ? is_rvc(h0[17:16]) : is_rvc(h0[1:0]);
        raw_instr = '0;
        out_s     = '0;
        if (!offset_q) begin
            raw_instr   = comp ? {16'h0000, h0[15:0]} : h0;
            out_s.valid = (count != '0);
        end else begin
            // A 32-bit instruction starting in the upper half straddles into h1.
            raw_instr   = comp ? {16'h0000, h0[31:16]} : {h1[15:0], h0[31:16]};
            out_s.valid = comp ? (count != '0) : (count > CNT_ONE);
        end
        out_s.instr   = out_s.valid ? raw_instr : '0;
        out_s.pc      = out_s.valid ? pc_q : '0;
        out_s.is_comp = out_s.valid && comp;
    end

    assign fire = out_s.valid && bus.instr_ready_i && !flush_i;
    assign push = rsp_s.ack && !drop_q && !flush_i;
    // Only an RVC taken from the lower half leaves the head word in place.
    assign pop  = fire && (offset_q || !comp);

    pref_word_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush_i),
        .push      (push),
        .push_data (rsp_s.data),
        .pop       (pop),
        .count     (count),
        .head      (h0),
        .head_next (h1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= 1'b0;
            drop_q    <= 1'b0;
            offset_q  <= 1'b0;
            pc_q      <= RESET_PC;
            addr_q    <= RESET_PC;
        end else if (flush_i) begin
            offset_q <= flush_pc_i[1];
            pc_q     <= {flush_pc_i[XLEN-1:1], 1'b0};
            addr_q   <= {flush_pc_i[XLEN-1:2], 2'b00};
            if (rsp_s.ack) begin
                // The ack retires the only outstanding request; nothing is left to discard.
                pending_q <= 1'b0;
                drop_q    <= 1'b0;
            end else if (pending_q) begin
                drop_q <= 1'b1;
            end
        end else begin
            if (rsp_s.ack) begin
                pending_q <= 1'b0;
                if (drop_q) begin
                    drop_q <= 1'b0;
                end else begin
                    addr_q <= addr_q + XLEN'(4);
                end
            end
            if (req_s.req) begin
                pending_q <= 1'b1;
            end
            if (fire) begin
                pc_q <= pc_q + (comp ? XLEN'(2) : XLEN'(4));
                if (comp) begin
                    offset_q <= !offset_q;
                end
            end
        end
    end

    assign bus.fetch_req_o   = req_s.req;
    assign bus.fetch_addr_o  = req_s.addr;
    assign bus.instr_valid_o = out_s.valid;
    assign bus.instr_o       = out_s.instr;
    assign bus.pc_o          = out_s.pc;
    assign bus.is_comp_o     = out_s.is_comp;

`ifdef PREFETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (bus.instr_ready_i && !out_s.valid && !flush_i && (stall_cnt_o != '1)) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
            if (flush_i && (flush_cnt_o != '1)) begin
                flush_cnt_o <= flush_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Bench for instr_prefetch_buffer: directed scenarios plus a randomized run.
// A program image (associative array of words) feeds the icache responder; the
// expected instruction stream is decoded from that image at halfword granularity.
module tb_instr_prefetch_buffer;
    import prefetch_pkg::*;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic [31:0] flush_pc_i;

    always #5 clk = ~clk;

    instr_prefetch_buffer_if #(.XLEN(32)) bus();

`ifdef PREFETCH_STATS_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    instr_prefetch_buffer #(
        .DEPTH    (4),
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .flush_pc_i  (flush_pc_i),
        .bus         (bus)
`ifdef PREFETCH_STATS_EN
        ,
        .stall_cnt_o (stall_cnt),
        .flush_cnt_o (flush_cnt)
`endif
    );

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    int          ack_lat;          // >0 fixed latency, 0 never ack, <0 random 1..3
    int          req_cnt;
    logic [31:0] mem [logic [31:0]];
    logic [64:0] exp_q[$];         // directed expectations {is_comp, pc, instr}
    logic [31:0] exp_pc;
    bit          prev_flush;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (!mem.exists(a)) mem[a] = $urandom;
        return mem[a];
    endfunction

    function automatic logic [15:0] hw(input logic [31:0] a);
        logic [31:0] w;
        w = word_at({a[31:2], 2'b00});
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    function automatic void exp_push(input logic c, input logic [31:0] p, input logic [31:0] i);
        exp_q.push_back({c, p, i});
    endfunction

    // ---------------- icache responder ----------------
    initial begin : icache
        logic        req_seen;
        logic [31:0] addr_seen;
        logic [31:0] hold;
        bit          busy;
        int          wait_left;
        busy = 0;
        wait_left = 0;
        hold = '0;
        req_cnt = 0;
        bus.fetch_ack_i = 1'b0;
        bus.fetch_data_i = '0;
        forever begin
            @(negedge clk);
            req_seen  = bus.fetch_req_o;
            addr_seen = bus.fetch_addr_o;
            if (!rst) begin
                if (flush_i) chk("req_in_flush", 64'(req_seen), 64'd0);
                if (req_seen) begin
                    chk("one_outstanding", 64'(busy || bus.fetch_ack_i), 64'd0);
                    chk("addr_align", 64'(addr_seen[1:0]), 64'd0);
                end
            end
            @(posedge clk);
            #2;
            bus.fetch_ack_i = 1'b0;
            if (rst) begin
                busy = 0;
                req_cnt = 0;
            end else if (req_seen) begin
                busy = 1;
                hold = addr_seen;
                req_cnt++;
                wait_left = (ack_lat < 0) ? $urandom_range(1, 3) : ack_lat;
            end
            if (busy && wait_left != 0) begin
                if (wait_left == 1) begin
                    bus.fetch_ack_i  = 1'b1;
                    bus.fetch_data_i = word_at(hold);
                    busy = 0;
                end else begin
                    wait_left--;
                end
            end
        end
    end

    // ---------------- output monitor / reference model ----------------
    always @(negedge clk) begin : mon
        logic [15:0] lo;
        logic [31:0] e_instr;
        logic        e_comp;
        logic [64:0] d;
        if (rst) begin
            exp_pc = 32'h0;
            prev_flush = 0;
        end else begin
            if (prev_flush) chk("valid_after_flush", 64'(bus.instr_valid_o), 64'd0);
            if (bus.instr_valid_o && bus.instr_ready_i && !flush_i) begin
                lo      = hw(exp_pc);
                e_comp  = (lo[1:0] != 2'b11);
                e_instr = e_comp ? {16'h0000, lo} : {hw(exp_pc + 32'd2), lo};
                chk("mdl_pc", 64'(bus.pc_o), 64'(exp_pc));
                chk("mdl_instr", 64'(bus.instr_o), 64'(e_instr));
                chk("mdl_comp", 64'(bus.is_comp_o), 64'(e_comp));
                if (exp_q.size() != 0) begin
                    d = exp_q.pop_front();
                    chk("dir_instr", 64'(bus.instr_o), 64'(d[31:0]));
                    chk("dir_pc", 64'(bus.pc_o), 64'(d[63:32]));
                    chk("dir_comp", 64'(bus.is_comp_o), 64'(d[64]));
                end
                exp_pc = exp_pc + (e_comp ? 32'd2 : 32'd4);
            end
            if (flush_i) exp_pc = {flush_pc_i[31:1], 1'b0};
            prev_flush = flush_i;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        flush_i = 1'b0;
        bus.instr_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mem.delete();
        exp_q.delete();
    endtask

    task automatic wait_exp_size(input int n, input int budget, input string tag);
        int k = 0;
        while (exp_q.size() > n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk(tag, 64'(exp_q.size() <= n), 64'd1);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        rst = 1'b1;
        flush_i = 1'b0;
        flush_pc_i = '0;
        bus.instr_ready_i = 1'b0;
        ack_lat = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 64'(bus.fetch_req_o), 64'd0);
        chk("rst_addr", 64'(bus.fetch_addr_o), 64'd0);
        chk("rst_valid", 64'(bus.instr_valid_o), 64'd0);
        chk("rst_instr", 64'(bus.instr_o), 64'd0);
        chk("rst_pc", 64'(bus.pc_o), 64'd0);
        chk("rst_comp", 64'(bus.is_comp_o), 64'd0);
`ifdef PREFETCH_STATS_EN
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        chk("rst_flush_cnt", 64'(flush_cnt), 64'd0);
`endif

        // 1: four NOPs, one-cycle icache
        do_reset();
        for (int i = 0; i < 4; i++) begin
            mem[32'(i * 4)] = INSTR_NOP;
            exp_push(1'b0, 32'(i * 4), INSTR_NOP);
        end
        ack_lat = 1;
        bus.instr_ready_i = 1'b1;
        rst = 1'b0;
        wait_exp_size(0, 100, "t1_timeout");

        // 2: two RVC in one word, then a 32-bit word
        do_reset();
        mem[32'h0] = 32'h4501_4581;
        mem[32'h4] = 32'h0000_0013;
        exp_push(1'b1, 32'h0, 32'h0000_4581);
        exp_push(1'b1, 32'h2, 32'h0000_4501);
        exp_push(1'b0, 32'h4, 32'h0000_0013);
        bus.instr_ready_i = 1'b1;
        rst = 1'b0;
        wait_exp_size(0, 100, "t2_timeout");

        // 3: 32-bit instruction straddling two words, slow icache
        do_reset();
        mem[32'h0] = 32'h0013_4581;
        mem[32'h4] = 32'hABCD_0000;
        exp_push(1'b1, 32'h0, 32'h0000_4581);
        exp_push(1'b0, 32'h2, 32'h0000_0013);
        exp_push(1'b1, 32'h6, 32'h0000_ABCD);
        ack_lat = 4;
        bus.instr_ready_i = 1'b1;
        rst = 1'b0;
        wait_exp_size(2, 100, "t3_first_timeout");
        @(negedge clk);
        chk("t3_wait_word1", 64'(bus.instr_valid_o), 64'd0);
        wait_exp_size(0, 100, "t3_timeout");

        // 4: flush while the fetch of 0x8 is pending; its ack must be dropped
        do_reset();
        mem[32'h8]    = 32'hDEAD_BEEF;
        mem[32'h1000] = 32'h4505_1111;
        ack_lat = 3;
        rst = 1'b0;
        begin
            int k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!(bus.fetch_req_o && bus.fetch_addr_o == 32'h8) && k < 60);
            chk("t4_req8_timeout", 64'(k < 60), 64'd1);
        end
        @(posedge clk);
        #1;
        flush_i = 1'b1;
        flush_pc_i = 32'h0000_1002;
        bus.instr_ready_i = 1'b1;
        exp_push(1'b1, 32'h1002, 32'h0000_4505);
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        begin
            int k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!bus.fetch_req_o && k < 60);
            chk("t4_newreq_timeout", 64'(k < 60), 64'd1);
            chk("t4_new_addr", 64'(bus.fetch_addr_o), 64'h1000);
        end
        wait_exp_size(0, 100, "t4_timeout");

        // 5: back-pressure fills the FIFO, then fetching resumes
        do_reset();
        ack_lat = 1;
        rst = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("t5_req_count_full", 64'(req_cnt), 64'd4);
        chk("t5_req_stopped", 64'(bus.fetch_req_o), 64'd0);
        chk("t5_valid_held", 64'(bus.instr_valid_o), 64'd1);
        @(posedge clk);
        #1;
        bus.instr_ready_i = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("t5_resumed", 64'(req_cnt > 4), 64'd1);

        // randomized: random latency, ready and redirects
        do_reset();
        ack_lat = -1;
        rst = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #1;
            bus.instr_ready_i = ($urandom_range(0, 3) != 0);
            flush_i = ($urandom_range(0, 40) == 0);
            flush_pc_i = 32'h2000 + 32'($urandom_range(0, 1023));
        end
        @(posedge clk);
        #1;
        flush_i = 1'b0;

`ifdef PREFETCH_STATS_EN
        // 6: three flushes and five starved ready cycles, icache never answers
        do_reset();
        ack_lat = 0;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            flush_i = 1'b1;
            flush_pc_i = 32'h40;
            @(posedge clk);
            #1;
            flush_i = 1'b0;
            repeat (2) @(posedge clk);
        end
        #1;
        bus.instr_ready_i = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        bus.instr_ready_i = 1'b0;
        @(negedge clk);
        chk("t6_flush_cnt", 64'(flush_cnt), 64'd3);
        chk("t6_stall_cnt", 64'(stall_cnt), 64'd5);
        do_reset();
        ack_lat = 1;
        rst = 1'b0;
`endif

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
